// File: rtl/mul_ctrl.sv
// Execute-stage sequencer for the 2-cycle multiplier (mul.w / mulh.w / mulh.wu).
// Holds a one-entry product cache so paired low/high requests issue only once.
module mul_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [31:0]      src_a,
  input  logic [31:0]      src_b,
  input  logic             is_flush,
  input  logic             is_stall,
  output logic             stall_req,
  output logic             res_valid,
  output logic [31:0]      res,
  output logic             mul_en,
  output logic             mul_signed,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_flush,
  input  logic [63:0]      mul_out,
  input  logic             mul_done,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_op_hi;
  logic             r_op_signed;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [31:0]      r_res;
  logic             r_res_valid;
  logic             r_c_valid;
  logic             r_c_signed;
  logic [31:0]      r_c_a;
  logic [31:0]      r_c_b;
  logic [63:0]      r_c_prod;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_hit_cnt;

  logic             w_hi;
  logic             w_signed;
  logic             w_key_match;
  logic             w_hit;
  logic             w_accept;

  // Op decode: only mulh.wu is unsigned; reserved 11 behaves as mul.w.
  always_comb begin
    w_hi     = 1'b0;
    w_signed = 1'b1;
    case (op)
      2'b00:   begin w_hi = 1'b0; w_signed = 1'b1; end
      2'b01:   begin w_hi = 1'b1; w_signed = 1'b1; end
      2'b10:   begin w_hi = 1'b1; w_signed = 1'b0; end
      default: begin w_hi = 1'b0; w_signed = 1'b1; end
    endcase
  end

  // The low half is signedness-independent, so mul.w ignores key_signed.
  assign w_key_match = r_c_valid && (r_c_a == src_a) && (r_c_b == src_b);
  assign w_hit       = w_key_match && (!w_hi || (r_c_signed == w_signed));
  assign w_accept    = (r_state == S_IDLE) && op_valid && !is_flush;

  assign mul_en    = w_accept && !w_hit;
  assign mul_flush = is_flush && (r_state == S_WAIT);
  assign stall_req = op_valid && (r_state != S_HOLD) && !is_flush;
  assign res_valid = r_res_valid;
  assign res       = r_res;
  assign issue_cnt = r_issue_cnt;
  assign hit_cnt   = r_hit_cnt;

  // Operand steering: live sources while idle, latched op otherwise.
  always_comb begin
    if (r_state == S_IDLE) begin
      mul_a      = src_a;
      mul_b      = src_b;
      mul_signed = w_signed;
    end else begin
      mul_a      = r_op_a;
      mul_b      = r_op_b;
      mul_signed = r_op_signed;
    end
  end

  // Sequencer; flush outranks completion and retire in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op_hi     <= 1'b0;
      r_op_signed <= 1'b0;
      r_op_a      <= 32'd0;
      r_op_b      <= 32'd0;
      r_res       <= 32'd0;
      r_res_valid <= 1'b0;
      r_c_valid   <= 1'b0;
      r_c_signed  <= 1'b0;
      r_c_a       <= 32'd0;
      r_c_b       <= 32'd0;
      r_c_prod    <= 64'd0;
      r_issue_cnt <= {CNT_W{1'b0}};
      r_hit_cnt   <= {CNT_W{1'b0}};
    end else if (is_flush) begin
      r_state     <= S_IDLE;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_hit) begin
            r_res       <= w_hi ? r_c_prod[63:32] : r_c_prod[31:0];
            r_res_valid <= 1'b1;
            r_hit_cnt   <= r_hit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state     <= S_HOLD;
          end else if (w_accept) begin
            r_op_hi     <= w_hi;
            r_op_signed <= w_signed;
            r_op_a      <= src_a;
            r_op_b      <= src_b;
            r_issue_cnt <= r_issue_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state     <= S_WAIT;
          end else begin
            r_state     <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (mul_done) begin
            r_c_valid   <= 1'b1;
            r_c_signed  <= r_op_signed;
            r_c_a       <= r_op_a;
            r_c_b       <= r_op_b;
            r_c_prod    <= mul_out;
            r_res       <= r_op_hi ? mul_out[63:32] : mul_out[31:0];
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_state     <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (!is_stall) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state     <= S_HOLD;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural 2-cycle multiplier model.
module tb_mul_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        is_flush = 1'b0;
  logic        is_stall = 1'b0;
  logic        stall_req, res_valid, mul_en, mul_signed, mul_flush;
  logic [31:0] res, mul_a, mul_b;
  logic [63:0] mul_out;
  logic        mul_done;
  logic [31:0] issue_cnt, hit_cnt;

  int vecs = 0;
  int errs = 0;

  mul_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .is_flush(is_flush), .is_stall(is_stall),
    .stall_req(stall_req), .res_valid(res_valid), .res(res),
    .mul_en(mul_en), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_flush(mul_flush), .mul_out(mul_out), .mul_done(mul_done),
    .issue_cnt(issue_cnt), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier model: product on mul_out with mul_done two cycles after mul_en.
  logic        m_v1, m_v2;
  logic [63:0] m_p1, m_out;
  logic signed [63:0] m_sa, m_sb;
  always_comb begin
    m_sa = {{32{mul_a[31]}}, mul_a};
    m_sb = {{32{mul_b[31]}}, mul_b};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v1 <= 1'b0; m_v2 <= 1'b0; m_p1 <= 64'd0; m_out <= 64'd0;
    end else begin
      m_v1 <= mul_en;
      if (mul_en) m_p1 <= mul_signed ? 64'(m_sa * m_sb) : ({32'd0, mul_a} * {32'd0, mul_b});
      m_v2 <= m_v1 && !mul_flush;
      if (m_v1) m_out <= m_p1;
    end
  end
  assign mul_done = m_v2;
  assign mul_out  = m_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
  endtask

  initial begin
    #12 rst = 1'b0;
    step();
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res", {32'd0, res}, 64'd0);
    chk("rst_issue", {32'd0, issue_cnt}, 64'd0);
    chk("rst_hit", {32'd0, hit_cnt}, 64'd0);

    // 1: cold miss mul.w
    drive(2'b00, 32'hFFFFFFFF, 32'h00000002); #1;
    chk("t1_en_t", {63'd0, mul_en}, 64'd1);
    chk("t1_signed", {63'd0, mul_signed}, 64'd1);
    chk("t1_stall_t", {63'd0, stall_req}, 64'd1);
    step();
    chk("t1_en_t1", {63'd0, mul_en}, 64'd0);
    chk("t1_stall_t1", {63'd0, stall_req}, 64'd1);
    chk("t1_rv_t1", {63'd0, res_valid}, 64'd0);
    step();
    chk("t1_stall_t2", {63'd0, stall_req}, 64'd1);
    chk("t1_rv_t2", {63'd0, res_valid}, 64'd0);
    step();
    chk("t1_rv_t3", {63'd0, res_valid}, 64'd1);
    chk("t1_res", {32'd0, res}, 64'hFFFFFFFE);
    chk("t1_stall_t3", {63'd0, stall_req}, 64'd0);
    chk("t1_issue", {32'd0, issue_cnt}, 64'd1);
    op_valid = 1'b0;
    step();
    chk("t1_retire", {63'd0, res_valid}, 64'd0);

    // 2: mulh.w hit, then mulh.wu miss on signedness
    drive(2'b01, 32'hFFFFFFFF, 32'h00000002); #1;
    chk("t2_hit_noen", {63'd0, mul_en}, 64'd0);
    step();
    chk("t2_hit_rv", {63'd0, res_valid}, 64'd1);
    chk("t2_hit_res", {32'd0, res}, 64'hFFFFFFFF);
    chk("t2_hit_cnt", {32'd0, hit_cnt}, 64'd1);
    op_valid = 1'b0;
    step();
    drive(2'b10, 32'hFFFFFFFF, 32'h00000002); #1;
    chk("t2_wu_en", {63'd0, mul_en}, 64'd1);
    chk("t2_wu_unsigned", {63'd0, mul_signed}, 64'd0);
    step(); step(); step();
    chk("t2_wu_rv", {63'd0, res_valid}, 64'd1);
    chk("t2_wu_res", {32'd0, res}, 64'h00000001);
    chk("t2_wu_issue", {32'd0, issue_cnt}, 64'd2);
    op_valid = 1'b0;
    step();

    // 3: signed min*min high half, then mul.w hit
    drive(2'b01, 32'h80000000, 32'h80000000);
    step(); step(); step();
    chk("t3_rv", {63'd0, res_valid}, 64'd1);
    chk("t3_res", {32'd0, res}, 64'h40000000);
    chk("t3_issue", {32'd0, issue_cnt}, 64'd3);
    op_valid = 1'b0;
    step();
    drive(2'b00, 32'h80000000, 32'h80000000); #1;
    chk("t3_hit_noen", {63'd0, mul_en}, 64'd0);
    step();
    chk("t3_hit_res", {32'd0, res}, 64'h00000000);
    chk("t3_hit_rv", {63'd0, res_valid}, 64'd1);
    chk("t3_hit_cnt", {32'd0, hit_cnt}, 64'd2);
    op_valid = 1'b0;
    step();

    // 4: flush in the cycle after issue
    drive(2'b00, 32'd3, 32'd5);
    step();
    op_valid = 1'b0; is_flush = 1'b1; #1;
    chk("t4_mul_flush", {63'd0, mul_flush}, 64'd1);
    chk("t4_stall_flush", {63'd0, stall_req}, 64'd0);
    step();
    is_flush = 1'b0;
    chk("t4_rv0", {63'd0, res_valid}, 64'd0);
    step(); step();
    chk("t4_rv_late", {63'd0, res_valid}, 64'd0);
    chk("t4_issue", {32'd0, issue_cnt}, 64'd4);
    drive(2'b11, 32'd3, 32'd5); is_flush = 1'b1; #1;
    chk("t4_idle_flush_noen", {63'd0, mul_en}, 64'd0);
    step();
    is_flush = 1'b0; #1;
    chk("t4_idle_flush_issue", {32'd0, issue_cnt}, 64'd4);
    chk("t4_re_miss_en", {63'd0, mul_en}, 64'd1);
    step(); step(); step();
    chk("t4_re_res", {32'd0, res}, 64'd15);
    chk("t4_re_issue", {32'd0, issue_cnt}, 64'd5);
    op_valid = 1'b0;
    step();

    // 5: stall in HOLD for 3 cycles
    drive(2'b00, 32'd3, 32'd5);
    step();
    is_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_rv_hold", {63'd0, res_valid}, 64'd1);
      chk("t5_res_hold", {32'd0, res}, 64'd15);
      chk("t5_stall_req", {63'd0, stall_req}, 64'd0);
      step();
    end
    is_stall = 1'b0; op_valid = 1'b0;
    chk("t5_rv_4th", {63'd0, res_valid}, 64'd1);
    step();
    chk("t5_retired", {63'd0, res_valid}, 64'd0);
    chk("t5_hit_cnt", {32'd0, hit_cnt}, 64'd3);

    // 6: asynchronous reset during WAIT
    drive(2'b00, 32'd7, 32'd9);
    step();
    op_valid = 1'b0;
    #2 rst = 1'b1; #1;
    chk("t6_rv", {63'd0, res_valid}, 64'd0);
    chk("t6_res", {32'd0, res}, 64'd0);
    chk("t6_issue", {32'd0, issue_cnt}, 64'd0);
    chk("t6_hit", {32'd0, hit_cnt}, 64'd0);
    step();
    rst = 1'b0;
    step();
    drive(2'b00, 32'd7, 32'd9); #1;
    chk("t6_miss_en", {63'd0, mul_en}, 64'd1);
    step(); step(); step();
    chk("t6_res_after", {32'd0, res}, 64'd63);
    chk("t6_issue_after", {32'd0, issue_cnt}, 64'd1);
    op_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Execute-stage sequencer for the 2-cycle multiplier datapath; implements LoongArch mul.w, mulh.w and mulh.wu.
- Latches the op, issues it to the multiplier, waits for done, and selects the high or low half of the product.
- Holds the result across pipeline stalls and aborts cleanly on flush.
- Keeps a one-entry product cache, so a mul.w/mulh pair on the same operands issues to the multiplier only once.

Parameters:
- CNT_W, 32, width of the perf counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- op_valid  in  1  pipeline presents a mul op
- op  in  2  00 mul.w, 01 mulh.w, 10 mulh.wu, 11 treated as mul.w
- src_a, src_b  in  32  operands
- is_flush  in  1  pipeline flush
- is_stall  in  1  downstream stall; result must be held
- stall_req  out  1  hold upstream; op not yet complete
- res_valid  out  1  res is valid
- res  out  32  selected result half
- mul_en  out  1  to multiplier en
- mul_signed  out  1  to multiplier is_signed
- mul_a, mul_b  out  32  to multiplier a, b
- mul_flush  out  1  to multiplier is_flush
- mul_out  in  64  multiplier product
- mul_done  in  1  multiplier done; product on mul_out valid
- issue_cnt  out  CNT_W  ops sent to the multiplier
- hit_cnt  out  CNT_W  ops served from the cache

Behaviour:
- Reset: state IDLE, res_valid=0, res=0, cache invalid, counters=0. All other registers clear to 0. Reset mid-operation aborts immediately.
- The multiplier's is_stall is tied low by the integrator. The controller always consumes mul_done the cycle it appears.
- Signedness: mulh.w is signed; mulh.wu is unsigned; mul.w is issued signed (low half is identical either way).
- Cache state: valid, key_a, key_b, key_signed, prod[63:0].
- Cache hit:
  - mul.w: valid & key_a==src_a & key_b==src_b (any key_signed).
  - mulh.*: additionally key_signed == requested signedness.
- FSM IDLE:
  - op_valid & ~is_flush & hit: capture res from cache prod, hit_cnt++, go HOLD. res_valid rises next cycle (latency 1).
  - op_valid & ~is_flush & miss: mul_en=1 (combinational). Latch op/a/b/signed into op registers, issue_cnt++, go WAIT.
- FSM WAIT:
  - mul_en=0; mul_a/mul_b/mul_signed driven from op registers.
  - On mul_done: load cache (valid=1, key from op registers, prod=mul_out). Capture res = hi ? mul_out[63:32] : mul_out[31:0]. Go HOLD.
  - Miss latency: op accepted at cycle t, mul_done at t+2, res_valid at t+3.
- FSM HOLD:
  - res_valid=1; res stable.
  - ~is_stall: retire and go IDLE (res_valid=0 next cycle).
  - is_stall: remain in HOLD.
  - No back-to-back acceptance; the next op is accepted from IDLE.
- mul_a/mul_b in IDLE: follow src_a/src_b.
- stall_req: op_valid & (state != HOLD) & ~is_flush.
- Flush:
  - Any state, state goes to IDLE next cycle; res_valid=0.
  - An op presented with flush in IDLE is ignored; no counter increment.
  - mul_flush = is_flush & (state==WAIT).
  - A flushed WAIT does not update the cache; the cache is never invalidated by flush.
  - Flush outranks a simultaneous mul_done and a simultaneous ~is_stall retire.
- Counters: wrap modulo 2^CNT_W, no saturation.
- Reserved op 11: identical to mul.w in every respect, including hit rule and result half.

Test Plan:
1. mul.w a=0xFFFFFFFF, b=0x00000002, cold cache -> mul_en pulses 1 cycle, mul_signed=1. res_valid at t+3, res=0xFFFFFFFE. issue_cnt=1, stall_req high t..t+2.
2. Then mulh.w with the same operands -> no mul_en, res=0xFFFFFFFF at t+1, hit_cnt=1. Then mulh.wu with the same operands -> miss (signedness differs), res=0x00000001, issue_cnt=2.
3. mulh.w a=b=0x80000000 -> res=0x40000000. Following mul.w with the same operands hits, res=0x00000000.
4. Miss op with is_flush asserted in the cycle after issue -> mul_flush=1, res_valid never rises, state IDLE. Repeating the op misses (issue_cnt increments again).
5. HOLD with is_stall high 3 cycles -> res and res_valid stable 3 cycles, stall_req=0. Retire on the 4th cycle.
6. Assert rst during WAIT, asynchronously mid-cycle -> res_valid=0, res=0 and counters=0 immediately. The next identical op misses.
